// File: rtl/fetch_controller_pkg.sv
// Shared processor definitions: instruction type codes, field positions, fetch FSM states.
// Latency: n/a (definitions only).
// Backpressure: n/a.
// Instruction words are numbered MSB-first in the ISA manual (bit 0 = MSB); the
// positions below are the equivalent little-endian [31:0] indices.
package fetch_controller_pkg;

   localparam logic [1:0] R_TYPE = 2'b00;
   localparam logic [1:0] I_TYPE = 2'b01;
   localparam logic [1:0] S_TYPE = 2'b10;
   localparam logic [1:0] J_TYPE = 2'b11;

   // ISA Function[0:4] -> [31:27], Imm[5:28] -> [26:3], Type[29:30] -> [2:1], Stop[31] -> [0]
   localparam int FUNC_MSB = 31;
   localparam int FUNC_LSB = 27;
   localparam int IMM_MSB  = 26;
   localparam int IMM_LSB  = 3;
   localparam int TYPE_MSB = 2;
   localparam int TYPE_LSB = 1;
   localparam int STOP_BIT = 0;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FETCH = 2'd1,
      ST_HALT  = 2'd2,
      ST_FAULT = 2'd3
   } fetch_state_t;

   // Word-aligned and inside the instruction memory.
   function automatic logic pc_in_range(input logic [31:0] addr, input logic [31:0] words);
      return (addr[1:0] == 2'b00) && ({2'b00, addr[31:2]} < words);
   endfunction

endpackage

// File: rtl/fetch_controller_next_pc_unit.sv
// Next-PC computation: sequential or J-type target, plus legality of that target and of a redirect.
// Latency: purely combinational.
// Backpressure: none; the caller decides whether to load the result.
// Ports: pc/instruction/redirect_target in; fetch_next, fetch_next_ok, redirect_ok, is_stop out.
module next_pc_unit
   import fetch_controller_pkg::*;
#(
   parameter int unsigned IMEM_WORDS = 256
) (
   input  logic [31:0]      pc,
   input  logic [IMM_MSB:0] instruction,
   input  logic [31:0]      redirect_target,
   output logic [31:0]      fetch_next,
   output logic             fetch_next_ok,
   output logic             redirect_ok,
   output logic             is_stop
);

   logic [23:0] imm;
   logic [1:0]  itype;
   logic [31:0] seq_pc;
   logic [31:0] jump_offset;

   assign imm         = instruction[IMM_MSB:IMM_LSB];
   assign itype       = instruction[TYPE_MSB:TYPE_LSB];
   assign is_stop     = instruction[STOP_BIT];
   assign seq_pc      = pc + 32'd4;
   // Word offset, sign-extended and scaled to bytes; wrap past 2^32 is left to the range check.
   assign jump_offset = {{6{imm[23]}}, imm, 2'b00};

   assign fetch_next    = (itype == J_TYPE) ? (seq_pc + jump_offset) : seq_pc;
   assign fetch_next_ok = pc_in_range(fetch_next, 32'(IMEM_WORDS));
   assign redirect_ok   = pc_in_range(redirect_target, 32'(IMEM_WORDS));

endmodule

// File: rtl/fetch_controller.sv
// Instruction fetch stage: drives pc to imem, registers the returned word with its address.
// Latency: instruction at pc appears on if_instr one clock later; one instruction per unstalled cycle.
// Backpressure: stall freezes pc and if_* outputs; redirect overrides stall and flushes one cycle.
// Ports: clock, reset (async active-low), start, instruction, stall, redirect_valid/target in;
//        pc, if_instr, if_pc, if_valid, halted, fault out.
module fetch_controller
   import fetch_controller_pkg::*;
#(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter int unsigned IMEM_WORDS = 256
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        start,
   input  logic [31:0] instruction,
   input  logic        stall,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_target,
   output logic [31:0] pc,
   output logic [31:0] if_instr,
   output logic [31:0] if_pc,
   output logic        if_valid,
   output logic        halted,
   output logic        fault
);

   fetch_state_t state_q, state_d;
   logic [31:0]  pc_d, if_instr_d, if_pc_d;
   logic         if_valid_d;

   logic [31:0]  fetch_next;
   logic         fetch_next_ok, redirect_ok, is_stop;

   next_pc_unit #(.IMEM_WORDS(IMEM_WORDS)) u_next_pc (
      .pc              (pc),
      .instruction     (instruction[IMM_MSB:0]),
      .redirect_target (redirect_target),
      .fetch_next      (fetch_next),
      .fetch_next_ok   (fetch_next_ok),
      .redirect_ok     (redirect_ok),
      .is_stop         (is_stop)
   );

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q  <= ST_IDLE;
         pc       <= RESET_PC;
         if_instr <= 32'd0;
         if_pc    <= 32'd0;
         if_valid <= 1'b0;
      end else begin
         state_q  <= state_d;
         pc       <= pc_d;
         if_instr <= if_instr_d;
         if_pc    <= if_pc_d;
         if_valid <= if_valid_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      pc_d       = pc;
      if_instr_d = if_instr;
      if_pc_d    = if_pc;
      if_valid_d = if_valid;
      case (state_q)
         ST_IDLE: begin
            pc_d       = RESET_PC;
            if_valid_d = 1'b0;
            if (start) state_d = ST_FETCH;
         end
         ST_FETCH: begin
            if (start) begin
               pc_d       = RESET_PC;
               if_valid_d = 1'b0;
            end else if (redirect_valid) begin
               // Flush: the word at the old pc is dropped.
               if_valid_d = 1'b0;
               if (redirect_ok) pc_d = redirect_target;
               else             state_d = ST_FAULT;
            end else if (!stall) begin
               if (is_stop) begin
                  // Stop instruction is still delivered to decode; pc parks on it.
                  if_instr_d = instruction;
                  if_pc_d    = pc;
                  if_valid_d = 1'b1;
                  state_d    = ST_HALT;
               end else if (fetch_next_ok) begin
                  if_instr_d = instruction;
                  if_pc_d    = pc;
                  if_valid_d = 1'b1;
                  pc_d       = fetch_next;
               end else begin
                  // pc keeps its last legal value for debug.
                  if_valid_d = 1'b0;
                  state_d    = ST_FAULT;
               end
            end
         end
         ST_HALT, ST_FAULT: begin
            if_valid_d = 1'b0;
            if (start) begin
               pc_d    = RESET_PC;
               state_d = ST_FETCH;
            end
         end
         default: begin
            state_d    = ST_IDLE;
            pc_d       = RESET_PC;
            if_valid_d = 1'b0;
         end
      endcase
   end

   assign halted = (state_q == ST_HALT);
   assign fault  = (state_q == ST_FAULT);

endmodule

// File: tb/tb_fetch_controller.sv
// Directed bench for fetch_controller with a behavioural 256-word instruction memory.
// Latency: checks sampled 1ns after each rising edge.
// Backpressure: stall/redirect driven directly by the stimulus sequence.
module tb_fetch_controller;
   import fetch_controller_pkg::*;

   logic        clock = 1'b0;
   logic        reset;
   logic        start;
   logic [31:0] instruction;
   logic        stall;
   logic        redirect_valid;
   logic [31:0] redirect_target;
   logic [31:0] pc, if_instr, if_pc;
   logic        if_valid, halted, fault;

   logic [31:0] imem [0:255];
   int n_cmp = 0;
   int n_err = 0;

   fetch_controller #(.RESET_PC(32'h0), .IMEM_WORDS(256)) dut (
      .clock           (clock),
      .reset           (reset),
      .start           (start),
      .instruction     (instruction),
      .stall           (stall),
      .redirect_valid  (redirect_valid),
      .redirect_target (redirect_target),
      .pc              (pc),
      .if_instr        (if_instr),
      .if_pc           (if_pc),
      .if_valid        (if_valid),
      .halted          (halted),
      .fault           (fault)
   );

   always #5 clock = ~clock;

   assign instruction = imem[pc[9:2]];

   function automatic logic [31:0] mk(input logic [4:0] fn, input logic [1:0] ty,
                                      input logic [23:0] imm, input logic stop);
      return {fn, imm, ty, stop};
   endfunction

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic chk_fetch(input string tag, input logic [31:0] e_pc, input logic [31:0] e_ifpc,
                            input logic e_vld);
      chk({tag, ".pc"}, pc, e_pc);
      chk({tag, ".if_valid"}, {31'd0, if_valid}, {31'd0, e_vld});
      if (e_vld) chk({tag, ".if_pc"}, if_pc, e_ifpc);
   endtask

   logic [31:0] addi0, addi1, add_i, j_back, j_to8, stop_i;

   initial begin
      addi0  = mk(5'd1, I_TYPE, 24'd5, 1'b0);
      addi1  = mk(5'd1, I_TYPE, 24'd7, 1'b0);
      add_i  = mk(5'd2, R_TYPE, 24'd0, 1'b0);
      j_back = mk(5'd3, J_TYPE, 24'hFFFFFC, 1'b0);  // 16 - 16 = 0
      j_to8  = mk(5'd3, J_TYPE, 24'hFFFFF1, 1'b0);  // 0x44 - 60 = 8
      stop_i = mk(5'd4, R_TYPE, 24'd0, 1'b1);
      for (int i = 0; i < 256; i++) imem[i] = 32'd0;
      imem[0]  = addi0;
      imem[1]  = addi1;
      imem[2]  = add_i;
      imem[3]  = j_back;
      imem[16] = j_to8;

      reset = 1'b0; start = 1'b0; stall = 1'b0;
      redirect_valid = 1'b0; redirect_target = 32'd0;
      step(); step();
      chk("rst.pc", pc, 32'h0);
      chk("rst.if_instr", if_instr, 32'h0);
      chk("rst.flags", {28'd0, if_valid, halted, fault, 1'b0}, 32'h0);
      reset = 1'b1;
      step(); step();
      chk_fetch("idle", 32'h0, 32'h0, 1'b0);

      // Sequential program and J-type wrap back to 0
      start = 1'b1; step(); start = 1'b0;
      chk_fetch("start", 32'h0, 32'h0, 1'b0);
      step(); chk_fetch("seq0", 32'h4, 32'h0, 1'b1);
      chk("seq0.instr", if_instr, addi0);
      step(); chk_fetch("seq1", 32'h8, 32'h4, 1'b1);
      chk("seq1.instr", if_instr, addi1);
      step(); chk_fetch("seq2", 32'hC, 32'h8, 1'b1);
      chk("seq2.instr", if_instr, add_i);
      step(); chk_fetch("jmp", 32'h0, 32'hC, 1'b1);
      step(); chk_fetch("jmp.t", 32'h4, 32'h0, 1'b1);

      // Stall three cycles at pc=4, then redirect to 0x40 while still stalled
      stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step(); chk_fetch("stall", 32'h4, 32'h0, 1'b1);
         chk("stall.instr", if_instr, addi0);
      end
      redirect_valid = 1'b1; redirect_target = 32'h40;
      step(); redirect_valid = 1'b0; stall = 1'b0;
      chk_fetch("redir", 32'h40, 32'h0, 1'b0);
      step(); chk_fetch("redir.j", 32'h8, 32'h40, 1'b1);

      // Asynchronous reset with pc=8
      reset = 1'b0; #1;
      chk("arst.pc", pc, 32'h0);
      chk("arst.if_pc", if_pc, 32'h0);
      chk("arst.if_instr", if_instr, 32'h0);
      chk("arst.flags", {29'd0, if_valid, halted, fault}, 32'h0);
      step(); reset = 1'b1;
      step(); step();
      chk_fetch("arst.idle", 32'h0, 32'h0, 1'b0);

      // Stop bit at 16
      imem[3] = add_i;
      imem[4] = stop_i;
      start = 1'b1; step(); start = 1'b0;
      step(); step(); step(); step();
      chk_fetch("pre.stop", 32'h10, 32'hC, 1'b1);
      step(); chk_fetch("stop", 32'h10, 32'h10, 1'b1);
      chk("stop.instr", if_instr, stop_i);
      chk("stop.halted", {31'd0, halted}, 32'd1);
      redirect_valid = 1'b1; redirect_target = 32'h20;  // ignored while halted
      step(); redirect_valid = 1'b0;
      chk_fetch("halt", 32'h10, 32'h0, 1'b0);
      chk("halt.halted", {31'd0, halted}, 32'd1);
      start = 1'b1; step(); start = 1'b0;
      chk_fetch("restart", 32'h0, 32'h0, 1'b0);
      chk("restart.halted", {31'd0, halted}, 32'd0);
      step(); chk_fetch("restart.f", 32'h4, 32'h0, 1'b1);

      // Misaligned redirect
      redirect_valid = 1'b1; redirect_target = 32'h402;
      step(); redirect_valid = 1'b0;
      chk_fetch("mis", 32'h4, 32'h0, 1'b0);
      chk("mis.fault", {31'd0, fault}, 32'd1);
      step(); chk("mis.sticky", {31'd0, fault}, 32'd1);
      start = 1'b1; step(); start = 1'b0;
      chk("mis.clr", {31'd0, fault}, 32'd0);
      chk_fetch("mis.clr", 32'h0, 32'h0, 1'b0);
      step(); chk_fetch("mis.f", 32'h4, 32'h0, 1'b1);

      // Out-of-range redirect (first word past the memory)
      redirect_valid = 1'b1; redirect_target = 32'h400;
      step(); redirect_valid = 1'b0;
      chk_fetch("oor", 32'h4, 32'h0, 1'b0);
      chk("oor.fault", {31'd0, fault}, 32'd1);
      redirect_valid = 1'b1; redirect_target = 32'h20;  // ignored in fault
      step(); redirect_valid = 1'b0;
      chk("oor.ign", pc, 32'h4);
      start = 1'b1; step(); start = 1'b0;
      chk("oor.clr", {31'd0, fault}, 32'd0);
      step(); step(); chk_fetch("oor.f", 32'h8, 32'h4, 1'b1);

      // Start during fetch: restart with one flush cycle
      start = 1'b1; step(); start = 1'b0;
      chk_fetch("rstart", 32'h0, 32'h0, 1'b0);
      step(); chk_fetch("rstart.f", 32'h4, 32'h0, 1'b1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
